param_clk_divider: RTL and testbench

PARAM_CLK_DIVIDER -- requirements
Module: param_clk_divider

---
 rtl/param_clk_divider.sv | 96 +++++++++
 tb/tb_param_clk_divider.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/param_clk_divider.sv
// param_clk_divider: NCH independent programmable clock dividers with shadowed config and sync realign
module param_clk_divider #(
  parameter int NCH = 4,
  parameter int CW = 16,
  parameter int DEF_DIV = 21,
  parameter int DEF_EN = 0,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           reset,
  input  logic           clk100,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic [CW-1:0]  cfg_high,
  input  logic [CW-1:0]  cfg_phase,
  input  logic           cfg_en,
  input  logic           sync_in,
  output logic           cfg_ack,
  output logic           cfg_err,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pending
);
  typedef struct packed {
    logic [CW-1:0] div;
    logic [CW-1:0] high;
    logic [CW-1:0] phase;
    logic          en;
  } cfg_t;
  localparam cfg_t DEF_CFG = '{div: CW'(DEF_DIV), high: CW'(DEF_DIV / 2), phase: '0, en: (DEF_EN != 0)};
  cfg_t          act_q [NCH];
  cfg_t          act_d [NCH];
  cfg_t          sh_q  [NCH];
  cfg_t          sh_d  [NCH];
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];
  logic [NCH-1:0] pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, wr, ap;
  logic ack_q, err_q, sync_q, valid, sync_edge;
  cfg_t wcfg;
  assign cfg_ack = ack_q;
  assign cfg_err = err_q;
  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;
  // Write validation, shadow/apply handling, counter stepping and output decode per channel
  always_comb begin
    valid = cfg_div > CW'(1) && cfg_high != '0 && cfg_high < cfg_div && cfg_phase < cfg_div && int'(cfg_ch) < NCH;
    sync_edge = sync_in && !sync_q;
    wcfg = '{div: cfg_div, high: cfg_high, phase: cfg_phase, en: cfg_en};
    act_d = act_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    clk_d = '0;
    tick_d = '0;
    wr = '0;
    ap = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = cfg_we && valid && int'(cfg_ch) == i;
      ap[i] = pend_q[i] && (!act_q[i].en || cnt_q[i] >= act_q[i].div - CW'(1));
      act_d[i] = ap[i] ? sh_q[i] : act_q[i];
      sh_d[i] = wr[i] ? wcfg : sh_q[i];
      pend_d[i] = wr[i] || (pend_q[i] && !ap[i]);
      cnt_d[i] = ap[i] ? sh_q[i].phase :
                 (sync_edge && act_q[i].en) ? act_q[i].phase :
                 !act_q[i].en ? cnt_q[i] :
                 (cnt_q[i] >= act_q[i].div - CW'(1)) ? '0 : cnt_q[i] + CW'(1);
      clk_d[i] = act_q[i].en && cnt_q[i] < act_q[i].high;
      tick_d[i] = act_q[i].en && cnt_q[i] == '0;
    end
  end
  // State registers with asynchronous active-low reset restoring default config
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      act_q  <= '{default: DEF_CFG};
      sh_q   <= '{default: DEF_CFG};
      cnt_q  <= '{default: '0};
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      ack_q  <= cfg_we && valid;
      err_q  <= cfg_we && !valid;
      sync_q <= sync_in;
    end
  end
endmodule

// File: tb/tb_param_clk_divider.sv
// tb_param_clk_divider: directed self-checking bench for param_clk_divider
module tb_param_clk_divider;
  localparam int NCH = 3;
  localparam int CW = 16;
  logic reset = 1'b0, clk100 = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0, sync_in = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [CW-1:0] cfg_div = '0, cfg_high = '0, cfg_phase = '0;
  logic cfg_ack, cfg_err;
  logic [NCH-1:0] clk_out, tick, pending;
  int n_run = 0, n_fail = 0;
  logic [1:0] q_cfg[$];
  logic [1:0] q_wave[$];

  always #5 clk100 = ~clk100;

  param_clk_divider #(.NCH(NCH), .CW(CW), .DEF_DIV(21), .DEF_EN(1)) dut (
    .reset(reset), .clk100(clk100), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase), .cfg_en(cfg_en),
    .sync_in(sync_in), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  task automatic step();
    @(negedge clk100);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input int div, input int high, input int phase, input bit en, input bit ok, input string tag);
    cfg_ch = 2'(ch); cfg_div = CW'(div); cfg_high = CW'(high); cfg_phase = CW'(phase); cfg_en = en;
    cfg_we = 1'b1;
    q_cfg.push_back({ok, !ok});
    step();
    cfg_we = 1'b0;
    chk(tag, 64'({cfg_ack, cfg_err}), 64'(q_cfg.pop_front()));
  endtask

  task automatic meas(input int ch, output int hi, output int lo);
    int b = 0;
    while (clk_out[ch] && b < 200) begin step(); b++; end
    while (!clk_out[ch] && b < 400) begin step(); b++; end
    hi = 0;
    while (clk_out[ch] && hi < 200) begin step(); hi++; end
    lo = 0;
    while (!clk_out[ch] && lo < 200) begin step(); lo++; end
  endtask

  task automatic tper(input int ch, output int p);
    int b = 0;
    while (!tick[ch] && b < 200) begin step(); b++; end
    p = 0;
    do begin step(); p++; end while (!tick[ch] && p < 200);
  endtask

  task automatic wait_idle(input logic [NCH-1:0] m, output int k);
    k = 0;
    while ((pending & m) != '0 && k < 100) begin step(); k++; end
  endtask

  initial begin
    int hi, lo, p, k, c;
    logic acc;
    step(); step();
    chk("reset_outputs", 64'({clk_out, tick, pending, cfg_ack, cfg_err}), 64'd0);
    reset = 1'b1;
    step();
    chk("first_rise_clk", 64'(clk_out), 64'd7);
    chk("first_rise_tick", 64'(tick), 64'd7);
    meas(0, hi, lo);
    chk("def_high", 64'(hi), 64'd10);
    chk("def_low", 64'(lo), 64'd11);
    tper(0, p);
    chk("def_tick_period", 64'(p), 64'd21);

    wr(0, 10, 0, 0, 1, 0, "err_high0");
    wr(0, 10, 10, 0, 1, 0, "err_high_div");
    wr(0, 10, 5, 10, 1, 0, "err_phase_div");
    wr(3, 10, 5, 0, 1, 0, "err_ch_nch");
    wr(0, 1, 1, 0, 1, 0, "err_div1");
    chk("err_no_pending", 64'(pending), 64'd0);
    meas(0, hi, lo);
    chk("err_unchanged_high", 64'(hi), 64'd10);
    chk("err_unchanged_low", 64'(lo), 64'd11);

    wr(1, 21, 10, 0, 0, 1, "ack_disable_ch1");
    wait_idle(3'b010, k);
    chk("disable_applied", 64'(pending[1]), 64'd0);
    step(); step();
    acc = 1'b0;
    for (int i = 0; i < 25; i++) begin acc |= clk_out[1] | tick[1]; step(); end
    chk("disabled_quiet", 64'(acc), 64'd0);
    wr(1, 8, 2, 0, 1, 1, "ack_ch1_div8");
    chk("ch1_pending_set", 64'(pending[1]), 64'd1);
    step();
    chk("ch1_immediate_apply", 64'(pending[1]), 64'd0);
    meas(1, hi, lo);
    chk("ch1_high", 64'(hi), 64'd2);
    chk("ch1_low", 64'(lo), 64'd6);

    k = 0;
    while (!tick[0] && k < 100) begin step(); k++; end
    for (int i = 0; i < 5; i++) step();
    wr(0, 4, 2, 0, 1, 1, "ack_ch0_div4");
    chk("ch0_pending_mid", 64'(pending[0]), 64'd1);
    wait_idle(3'b001, k);
    chk("ch0_boundary_wait", 64'(k), 64'd14);
    meas(0, hi, lo);
    chk("ch0_new_high", 64'(hi), 64'd2);
    chk("ch0_new_low", 64'(lo), 64'd2);
    tper(0, p);
    chk("ch0_new_tick_period", 64'(p), 64'd4);

    wr(0, 10, 3, 0, 1, 1, "ack_sync_ch0");
    wr(1, 10, 3, 5, 1, 1, "ack_sync_ch1");
    wait_idle(3'b011, k);
    chk("sync_cfg_applied", 64'(pending), 64'd0);
    sync_in = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      c = (j - 1) % 10;
      q_wave.push_back({((c + 5) % 10) < 3, c < 3});
    end
    step();
    sync_in = 1'b0;
    step();
    for (int j = 1; j <= 20; j++) begin
      chk($sformatf("sync_wave_%0d", j), 64'(clk_out[1:0]), 64'(q_wave.pop_front()));
      step();
    end

    wr(0, 6, 3, 0, 1, 1, "ack_before_reset");
    chk("pending_before_reset", 64'(pending[0]), 64'd1);
    #1 reset = 1'b0;
    #1 chk("async_reset_outputs", 64'({clk_out, tick, pending, cfg_ack, cfg_err}), 64'd0);
    step();
    reset = 1'b1;
    step();
    chk("rerelease_rise", 64'(clk_out), 64'd7);
    chk("rerelease_pending", 64'(pending), 64'd0);
    meas(0, hi, lo);
    chk("restored_ch0_high", 64'(hi), 64'd10);
    chk("restored_ch0_low", 64'(lo), 64'd11);
    meas(1, hi, lo);
    chk("restored_ch1_high", 64'(hi), 64'd10);
    chk("restored_ch1_low", 64'(lo), 64'd11);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
